// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one integer ALU between the execute stage (port 0) and
// the branch/address unit (port 1). Round-robin grant, one operation per
// cycle, result captured into a per-requester one-entry response register.

package alu_pkg;
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_LUI   = 5'd10;
    localparam logic [4:0] ALU_AUIPC = 5'd11;
endpackage

// Purely combinational integer ALU; unknown operation codes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       sel,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [31:0]      imm,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] rd
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] imm_ext;

    assign shamt   = rs2[SHW-1:0];
    // Immediate is sign-extended (or truncated) to the datapath width.
    assign imm_ext = WIDTH'($signed(imm));

    // Operation decode.
    always_comb begin
        rd = '0;
        case (sel)
            ALU_ADD:   rd = rs1 + rs2;
            ALU_SUB:   rd = rs1 - rs2;
            ALU_SLL:   rd = rs1 << shamt;
            ALU_SLT:   rd = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            ALU_SLTU:  rd = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
            ALU_XOR:   rd = rs1 ^ rs2;
            ALU_SRL:   rd = rs1 >> shamt;
            ALU_SRA:   rd = $unsigned($signed(rs1) >>> shamt);
            ALU_OR:    rd = rs1 | rs2;
            ALU_AND:   rd = rs1 & rs2;
            ALU_LUI:   rd = imm_ext;
            ALU_AUIPC: rd = pc + imm_ext;
            default:   rd = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][WIDTH-1:0] req_rs1,
    input  logic [1:0][WIDTH-1:0] req_rs2,
    input  logic [1:0][31:0]      req_imm,
    input  logic [1:0][4:0]       req_sel,
    input  logic [1:0][WIDTH-1:0] req_pc,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [1:0][WIDTH-1:0] rsp_rd
);
    logic             prio_q, prio_d;
    logic [1:0]       full_q, full_d;
    logic [WIDTH-1:0] rsp_rd_q [2];

    logic [1:0]       elig;
    logic [1:0]       grant;
    logic             mux_idx;

    logic [4:0]       alu_sel;
    logic [WIDTH-1:0] alu_rs1, alu_rs2, alu_pc, alu_rd;
    logic [31:0]      alu_imm;

    // Eligibility and round-robin grant; nothing is accepted while in reset.
    always_comb begin
        elig  = req_valid & (~full_q | rsp_ready) & {2{rst_n}};
        grant = 2'b00;
        if (elig == 2'b11) begin
            grant[prio_q] = 1'b1;
        end else begin
            grant = elig;
        end
    end

    assign req_ready = grant;

    // Without a grant the ALU still sees requester prio; its result is dropped.
    assign mux_idx = grant[1] ? 1'b1 : (grant[0] ? 1'b0 : prio_q);
    assign alu_sel = req_sel[mux_idx];
    assign alu_rs1 = req_rs1[mux_idx];
    assign alu_rs2 = req_rs2[mux_idx];
    assign alu_imm = req_imm[mux_idx];
    assign alu_pc  = req_pc[mux_idx];

    alu #(.WIDTH(WIDTH)) u_alu (
        .sel (alu_sel),
        .rs1 (alu_rs1),
        .rs2 (alu_rs2),
        .imm (alu_imm),
        .pc  (alu_pc),
        .rd  (alu_rd)
    );

    // Next state: a grant fills its slot and hands priority to the other side;
    // a consumed slot empties unless it is refilled in the same cycle.
    always_comb begin
        prio_d = prio_q;
        if (|grant) begin
            prio_d = grant[0];
        end
        full_d = grant | (full_q & ~rsp_ready);
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
            full_q <= 2'b00;
        end else begin
            prio_q <= prio_d;
            full_q <= full_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            // Response data: loaded only on a grant, otherwise held.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rsp_rd_q[gi] <= '0;
                end else if (grant[gi]) begin
                    rsp_rd_q[gi] <= alu_rd;
                end
            end

            assign rsp_rd[gi] = rsp_rd_q[gi];
        end
    endgenerate

    assign rsp_valid = full_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: an observer pushes expected results on
// every accepted request and checks the grant against the arbitration rules;
// a separate monitor pops and compares whenever a response is consumed.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0][W-1:0] req_rs1, req_rs2, req_pc, rsp_rd;
    logic [1:0][31:0]  req_imm;
    logic [1:0][4:0]   req_sel;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic        m_prio = 1'b0;
    logic [1:0]  acc_last;
    logic [1:0]  pend;
    logic [1:0]  exp2;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .req_sel   (req_sel),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rd    (rsp_rd)
    );

    // Reference ALU, straight from the operation definitions.
    function automatic logic [31:0] ref_alu(logic [4:0] s, logic [31:0] a, logic [31:0] b,
                                            logic [31:0] imm, logic [31:0] pc);
        case (s)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_SLL:   return a << b[4:0];
            ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:   return a ^ b;
            ALU_SRL:   return a >> b[4:0];
            ALU_SRA:   return $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:    return a | b;
            ALU_AND:   return a & b;
            ALU_LUI:   return imm;
            ALU_AUIPC: return pc + imm;
            default:   return 32'd0;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic set_req(int i, logic [4:0] s, logic [31:0] a, logic [31:0] b,
                           logic [31:0] imm, logic [31:0] pc);
        req_valid[i] = 1'b1;
        req_sel[i]   = s;
        req_rs1[i]   = a;
        req_rs2[i]   = b;
        req_imm[i]   = imm;
        req_pc[i]    = pc;
    endtask

    task automatic rnd_req(int i);
        logic [31:0] b;
        b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        set_req(i, 5'($urandom_range(0, 15)), $urandom, b, $urandom, $urandom);
    endtask

    // One clock: sample what is accepted at the coming edge, then step past it.
    task automatic cycle();
        @(negedge clk);
        acc_last = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    // Observer: grant rules, occupancy, and pushing expected results on accept.
    always @(negedge clk) begin
        logic [1:0] occ, el, exp_g;
        if (!rst_n) begin
            check("reset_ready", 32'(req_ready), 32'd0);
            q0.delete();
            q1.delete();
            m_prio = 1'b0;
        end else begin
            occ = {q1.size() != 0, q0.size() != 0};
            check("rsp_valid", 32'(rsp_valid), 32'(occ));
            el = req_valid & (~occ | rsp_ready);
            if (el == 2'b11) exp_g = m_prio ? 2'b10 : 2'b01;
            else             exp_g = el;
            check("grant", 32'(req_ready), 32'(exp_g));
            check("grant_to_full", 32'(req_ready & occ & ~rsp_ready), 32'd0);
            if (req_valid[0] && req_ready[0]) begin
                q0.push_back(ref_alu(req_sel[0], req_rs1[0], req_rs2[0], req_imm[0], req_pc[0]));
                m_prio = 1'b1;
            end
            if (req_valid[1] && req_ready[1]) begin
                q1.push_back(ref_alu(req_sel[1], req_rs1[1], req_rs2[1], req_imm[1], req_pc[1]));
                m_prio = 1'b0;
            end
        end
    end

    // Monitor: compares each consumed response against the scoreboard.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (rsp_valid[0] && rsp_ready[0]) begin
                if (q0.size() == 0) check("rsp0_extra", 32'(q0.size()), 32'd1);
                else                check("rsp0_data", rsp_rd[0], q0.pop_front());
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                if (q1.size() == 0) check("rsp1_extra", 32'(q1.size()), 32'd1);
                else                check("rsp1_data", rsp_rd[1], q1.pop_front());
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_rs1   = '0;
        req_rs2   = '0;
        req_imm   = '0;
        req_sel   = '0;
        req_pc    = '0;

        // Reset held with both requesters valid.
        set_req(0, ALU_ADD, 32'd1, 32'd2, 32'd0, 32'd0);
        set_req(1, ALU_ADD, 32'd3, 32'd4, 32'd0, 32'd0);
        cycle();
        cycle();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rd0", rsp_rd[0], 32'd0);
        check("rst_rsp_rd1", rsp_rd[1], 32'd0);
        rst_n = 1'b1;
        cycle();
        check("first_grant", 32'(acc_last), 32'd1);
        req_valid[0] = 1'b0;
        rsp_ready    = 2'b11;
        cycle();
        check("second_grant", 32'(acc_last), 32'd2);
        req_valid = 2'b00;
        cycle();
        cycle();

        // Contention: grants must alternate 0,1,0,1,0,1.
        rsp_ready = 2'b11;
        rnd_req(0);
        rnd_req(1);
        for (int k = 0; k < 6; k++) begin
            cycle();
            exp2 = (k % 2 == 0) ? 2'b01 : 2'b10;
            check("contention_grant", 32'(acc_last), 32'(exp2));
            for (int i = 0; i < 2; i++) if (acc_last[i]) rnd_req(i);
        end
        req_valid = 2'b00;
        cycle();
        cycle();

        // Single add 5+3.
        set_req(0, ALU_ADD, 32'd5, 32'd3, 32'd0, 32'd0);
        cycle();
        check("single_grant", 32'(acc_last), 32'd1);
        req_valid = 2'b00;
        check("single_valid", 32'(rsp_valid[0]), 32'd1);
        check("single_rd", rsp_rd[0], 32'd8);
        cycle();

        // Backpressure on requester 1.
        rsp_ready = 2'b01;
        set_req(1, ALU_SUB, 32'd10, 32'd4, 32'd0, 32'd0);
        cycle();
        check("bp_first", 32'(acc_last), 32'd2);
        set_req(1, ALU_ADD, 32'd7, 32'd7, 32'd0, 32'd0);
        rnd_req(0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_grant", 32'(acc_last), 32'd1);
            check("bp_hold", rsp_rd[1], 32'd6);
            check("bp_valid", 32'(rsp_valid[1]), 32'd1);
            rnd_req(0);
        end
        req_valid[0] = 1'b0;
        rsp_ready[1] = 1'b1;
        cycle();
        check("bp_release", 32'(acc_last), 32'd2);
        req_valid = 2'b00;
        check("bp_second", rsp_rd[1], 32'd14);
        cycle();

        // Same-cycle drain and refill of slot 0.
        rsp_ready = 2'b00;
        set_req(0, ALU_LUI, 32'd0, 32'd0, 32'h1234_5000, 32'd0);
        cycle();
        check("lui_grant", 32'(acc_last), 32'd1);
        set_req(0, ALU_AUIPC, 32'd0, 32'd0, 32'h0000_1000, 32'h0000_0100);
        rsp_ready[0] = 1'b1;
        check("lui_rd", rsp_rd[0], 32'h1234_5000);
        cycle();
        check("refill_grant", 32'(acc_last), 32'd1);
        req_valid = 2'b00;
        check("refill_valid", 32'(rsp_valid[0]), 32'd1);
        check("refill_rd", rsp_rd[0], 32'h0000_1100);
        rsp_ready = 2'b11;
        cycle();

        // Random traffic; payload held stable until accepted.
        pend = 2'b00;
        for (int n = 0; n < 1000; n++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (acc_last[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    rnd_req(i);
                    pend[i] = 1'b1;
                end
                req_valid[i] = pend[i];
            end
            rsp_ready = 2'($urandom_range(0, 3));
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        cycle();
        cycle();
        cycle();
        check("final_q0_empty", 32'(q0.size()), 32'd0);
        check("final_q1_empty", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
